// File: rtl/seg_capture_decoder_if.sv
// Signal bundle between a multiplexed 7-segment display tap and seg_capture_decoder.
// Optional macro SEG_CAPTURE_DP_EN adds the decimal-point input and per-digit dp outputs.
interface seg_capture_decoder_if;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        upd;
  logic [1:0]  upd_idx;
  logic [3:0]  blank;
  logic        err;
`ifdef SEG_CAPTURE_DP_EN
  logic        dp;
  logic [3:0]  dp_out;

  modport master (
    output seg, an, err_clr, dp,
    input  digits, digit_valid, upd, upd_idx, blank, err, dp_out
  );
  modport slave (
    input  seg, an, err_clr, dp,
    output digits, digit_valid, upd, upd_idx, blank, err, dp_out
  );
`else
  modport master (
    output seg, an, err_clr,
    input  digits, digit_valid, upd, upd_idx, blank, err
  );
  modport slave (
    input  seg, an, err_clr,
    output digits, digit_valid, upd, upd_idx, blank, err
  );
`endif
endinterface

// File: rtl/seg_capture_decoder.sv
// Snoops a 4-digit multiplexed 7-segment display and recovers the hex value of each digit.
// Optional macro SEG_CAPTURE_DP_EN also captures the decimal point into dp_out.
module seg_capture_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_capture_decoder_if.slave  io_bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    COMMIT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] L_STABLE = 8'(STABLE_CYCLES);

  // Comparison key: {dp, seg, an} or {seg, an}; seg always sits at bits [10:4].
`ifdef SEG_CAPTURE_DP_EN
  localparam int                 KEY_W     = 12;
  localparam logic [KEY_W-1:0]   RESET_KEY = {1'b1, 7'h7F, 4'hF};
`else
  localparam int                 KEY_W     = 11;
  localparam logic [KEY_W-1:0]   RESET_KEY = {7'h7F, 4'hF};
`endif

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_next;
  logic               w_latch;

  logic [6:0]         r_s_seg;
  logic [3:0]         r_s_an;
  logic [KEY_W-1:0]   w_s_key;
  logic [KEY_W-1:0]   r_p_key;
  logic               w_one_active;
  logic [1:0]         w_s_idx;

  logic [KEY_W-1:0]   r_cmt_key;
  logic [1:0]         r_cmt_idx;
  logic               w_commit;
  logic [5:0]         w_dec;
  logic               w_dec_legal;
  logic               w_dec_blank;
  logic [3:0]         w_dec_val;
  logic               w_illegal;
  logic               r_err;

  logic [15:0]        w_digits;
  logic [3:0]         w_valid;
  logic [3:0]         w_blank;

  // Returns {legal_hex, blank, value}; all zero for an illegal pattern.
  function automatic logic [5:0] f_decode(input logic [6:0] s);
    logic [5:0] res;
    res = 6'b00_0000;
    case (s)
      7'h40: res = {2'b10, 4'h0};
      7'h79: res = {2'b10, 4'h1};
      7'h24: res = {2'b10, 4'h2};
      7'h30: res = {2'b10, 4'h3};
      7'h19: res = {2'b10, 4'h4};
      7'h12: res = {2'b10, 4'h5};
      7'h02: res = {2'b10, 4'h6};
      7'h78: res = {2'b10, 4'h7};
      7'h00: res = {2'b10, 4'h8};
      7'h10: res = {2'b10, 4'h9};
      7'h08: res = {2'b10, 4'hA};
      7'h03: res = {2'b10, 4'hB};
      7'h46: res = {2'b10, 4'hC};
      7'h21: res = {2'b10, 4'hD};
      7'h06: res = {2'b10, 4'hE};
      7'h0E: res = {2'b10, 4'hF};
      7'h7F: res = {2'b01, 4'h0};
      default: res = 6'b00_0000;
    endcase
    return res;
  endfunction

  // Input sampling; every decision below works on these registered copies.
`ifdef SEG_CAPTURE_DP_EN
  logic r_s_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_dp <= 1'b1;
    end else begin
      r_s_dp <= io_bus.dp;
    end
  end

  assign w_s_key = {r_s_dp, r_s_seg, r_s_an};
`else
  assign w_s_key = {r_s_seg, r_s_an};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_seg <= 7'h7F;
      r_s_an  <= 4'hF;
      r_p_key <= RESET_KEY;
    end else begin
      r_s_seg <= io_bus.seg;
      r_s_an  <= io_bus.an;
      r_p_key <= w_s_key;
    end
  end

  assign w_one_active = ($countones(~r_s_an) == 1);

  always_comb begin
    w_s_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!r_s_an[i]) begin
        w_s_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_next = 8'd0;
        if (w_one_active) begin
          w_state_next = TRACK;
          w_cnt_next   = 8'd1;
        end
      end
      TRACK: begin
        if (!w_one_active) begin
          w_state_next = IDLE;
          w_cnt_next   = 8'd0;
        end else begin
          if (w_s_key == r_p_key) begin
            w_cnt_next = (r_cnt >= L_STABLE) ? L_STABLE : r_cnt + 8'd1;
          end else begin
            w_cnt_next = 8'd1;
          end
          if (w_cnt_next == L_STABLE) begin
            w_state_next = COMMIT;
            w_latch      = 1'b1;
          end
        end
      end
      COMMIT: begin
        w_state_next = HOLD;
      end
      HOLD: begin
        // Compared against the committed sample so a change during COMMIT is not missed.
        if (w_s_key != r_cmt_key) begin
          if (w_one_active) begin
            w_state_next = TRACK;
            w_cnt_next   = 8'd1;
          end else begin
            w_state_next = IDLE;
            w_cnt_next   = 8'd0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmt_key <= RESET_KEY;
      r_cmt_idx <= 2'd0;
    end else if (w_latch) begin
      r_cmt_key <= w_s_key;
      r_cmt_idx <= w_s_idx;
    end
  end

  assign w_commit    = (r_state == COMMIT);
  assign w_dec       = f_decode(r_cmt_key[10:4]);
  assign w_dec_legal = w_dec[5];
  assign w_dec_blank = w_dec[4];
  assign w_dec_val   = w_dec[3:0];
  assign w_illegal   = w_commit && !w_dec_legal && !w_dec_blank;

  // A commit that sets err wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end else if (io_bus.err_clr) begin
      r_err <= 1'b0;
    end
  end

`ifdef SEG_CAPTURE_DP_EN
  logic [3:0] w_dp_out;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [3:0] r_dig;
      logic       r_vld;
      logic       r_blk;
      logic       w_hit;

      assign w_hit = w_commit && (r_cmt_idx == 2'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dig <= 4'h0;
          r_vld <= 1'b0;
          r_blk <= 1'b0;
        end else if (w_hit) begin
          if (w_dec_legal) begin
            r_dig <= w_dec_val;
            r_vld <= 1'b1;
            r_blk <= 1'b0;
          end else if (w_dec_blank) begin
            r_blk <= 1'b1;
          end
        end
      end

      assign w_digits[gi*4 +: 4] = r_dig;
      assign w_valid[gi]         = r_vld;
      assign w_blank[gi]         = r_blk;

`ifdef SEG_CAPTURE_DP_EN
      logic r_dpo;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_dpo <= 1'b0;
        end else if (w_hit && (w_dec_legal || w_dec_blank)) begin
          r_dpo <= ~r_cmt_key[11];
        end
      end

      assign w_dp_out[gi] = r_dpo;
`endif
    end
  endgenerate

  assign io_bus.digits      = w_digits;
  assign io_bus.digit_valid = w_valid;
  assign io_bus.blank       = w_blank;
  assign io_bus.upd         = w_commit;
  assign io_bus.upd_idx     = r_cmt_idx;
  assign io_bus.err         = r_err;
`ifdef SEG_CAPTURE_DP_EN
  assign io_bus.dp_out      = w_dp_out;
`endif

endmodule

// File: tb/tb_seg_capture_decoder.sv
// Self-checking bench for seg_capture_decoder: directed scenarios plus a randomized
// run-length stream checked against a run-based reference model.
module tb_seg_capture_decoder;

  localparam int S = 4;
  localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seg_capture_decoder_if bus ();

  seg_capture_decoder #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         upd_seen = 0;
  logic [1:0] last_idx = 2'd0;
  bit         clr_on_upd = 1'b0;

  // Model lookup: 0..15 legal value, 16 blank, -1 illegal.
  function automatic int f_lookup(input logic [6:0] s);
    if (s == 7'h7F) return 16;
    for (int v = 0; v < 16; v++) begin
      if (PAT[v] == s) return v;
    end
    return -1;
  endfunction

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.upd === 1'b1) begin
        upd_seen++;
        last_idx = bus.upd_idx;
        $display("t=%0t upd idx=%0d digits=%h valid=%b blank=%b err=%b",
                 $time, bus.upd_idx, bus.digits, bus.digit_valid, bus.blank, bus.err);
      end
      bus.err_clr = clr_on_upd && (bus.upd === 1'b1);
      bus.an      = an;
      bus.seg     = seg;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.an      = 4'hF;
    bus.seg     = 7'h7F;
    bus.err_clr = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    upd_seen = 0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.digits !== 16'h0)     begin errors++; $display("FAIL reset_digits got %h exp 0000", bus.digits); end
    checks++; if (bus.digit_valid !== 4'h0) begin errors++; $display("FAIL reset_valid got %b exp 0000", bus.digit_valid); end
    checks++; if (bus.blank !== 4'h0)       begin errors++; $display("FAIL reset_blank got %b exp 0000", bus.blank); end
    checks++; if (bus.upd !== 1'b0)         begin errors++; $display("FAIL reset_upd got %b exp 0", bus.upd); end
    checks++; if (bus.upd_idx !== 2'd0)     begin errors++; $display("FAIL reset_upd_idx got %0d exp 0", bus.upd_idx); end
    checks++; if (bus.err !== 1'b0)         begin errors++; $display("FAIL reset_err got %b exp 0", bus.err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    drive(4'hE, 7'h24, 12);
    drive(4'hF, 7'h7F, 3);
    checks++; if (upd_seen !== 1)                begin errors++; $display("FAIL single_upd_count got %0d exp 1", upd_seen); end
    checks++; if (last_idx !== 2'd0)             begin errors++; $display("FAIL single_upd_idx got %0d exp 0", last_idx); end
    checks++; if (bus.digits[3:0] !== 4'h2)      begin errors++; $display("FAIL single_digit got %h exp 2", bus.digits[3:0]); end
    checks++; if (bus.digit_valid !== 4'b0001)   begin errors++; $display("FAIL single_valid got %b exp 0001", bus.digit_valid); end
  endtask

  task automatic test_blank();
    drive(4'hE, 7'h7F, 6);
    drive(4'hF, 7'h7F, 2);
    checks++; if (bus.blank !== 4'b0001)         begin errors++; $display("FAIL blank_set got %b exp 0001", bus.blank); end
    checks++; if (bus.digits[3:0] !== 4'h2)      begin errors++; $display("FAIL blank_digit got %h exp 2", bus.digits[3:0]); end
    checks++; if (bus.digit_valid !== 4'b0001)   begin errors++; $display("FAIL blank_valid got %b exp 0001", bus.digit_valid); end
    drive(4'hE, 7'h78, 6);
    drive(4'hF, 7'h7F, 2);
    checks++; if (bus.blank !== 4'b0000)         begin errors++; $display("FAIL blank_clear got %b exp 0000", bus.blank); end
    checks++; if (bus.digits[3:0] !== 4'h7)      begin errors++; $display("FAIL blank_next_digit got %h exp 7", bus.digits[3:0]); end
  endtask

  task automatic test_sequence();
    apply_reset();
    drive(4'hE, 7'h30, 6);
    drive(4'hD, 7'h79, 6);
    drive(4'hB, 7'h0E, 6);
    drive(4'h7, 7'h40, 6);
    drive(4'hF, 7'h7F, 3);
    checks++; if (bus.digits !== 16'h0F13)       begin errors++; $display("FAIL seq_digits got %h exp 0f13", bus.digits); end
    checks++; if (bus.digit_valid !== 4'b1111)   begin errors++; $display("FAIL seq_valid got %b exp 1111", bus.digit_valid); end
    checks++; if (upd_seen !== 4)                begin errors++; $display("FAIL seq_upd_count got %0d exp 4", upd_seen); end
  endtask

  task automatic test_toggle();
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      drive(4'hE, (k % 2 == 0) ? 7'h24 : 7'h30, 3);
    end
    checks++; if (upd_seen !== 0)                begin errors++; $display("FAIL toggle_no_upd got %0d exp 0", upd_seen); end
    drive(4'hE, 7'h30, 4);
    drive(4'hF, 7'h7F, 3);
    checks++; if (upd_seen !== 1)                begin errors++; $display("FAIL toggle_upd_count got %0d exp 1", upd_seen); end
    checks++; if (bus.digits[3:0] !== 4'h3)      begin errors++; $display("FAIL toggle_digit got %h exp 3", bus.digits[3:0]); end
  endtask

  task automatic test_multi_anode();
    apply_reset();
    drive(4'hE, 7'h24, 6);
    drive(4'hF, 7'h7F, 2);
    upd_seen = 0;
    drive(4'hC, 7'h00, 20);
    drive(4'h0, 7'h00, 8);
    drive(4'hF, 7'h7F, 3);
    checks++; if (upd_seen !== 0)                begin errors++; $display("FAIL multi_no_upd got %0d exp 0", upd_seen); end
    checks++; if (bus.digits !== 16'h0002)       begin errors++; $display("FAIL multi_digits got %h exp 0002", bus.digits); end
    checks++; if (bus.digit_valid !== 4'b0001)   begin errors++; $display("FAIL multi_valid got %b exp 0001", bus.digit_valid); end
    checks++; if (bus.err !== 1'b0)              begin errors++; $display("FAIL multi_err got %b exp 0", bus.err); end
  endtask

  task automatic test_illegal();
    apply_reset();
    drive(4'hE, 7'h24, 6);
    drive(4'hD, 7'h55, 6);
    drive(4'hF, 7'h7F, 2);
    checks++; if (bus.err !== 1'b1)              begin errors++; $display("FAIL illegal_err_set got %b exp 1", bus.err); end
    checks++; if (bus.digit_valid !== 4'b0001)   begin errors++; $display("FAIL illegal_valid got %b exp 0001", bus.digit_valid); end
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    checks++; if (bus.err !== 1'b0)              begin errors++; $display("FAIL illegal_err_clr got %b exp 0", bus.err); end
    upd_seen   = 0;
    clr_on_upd = 1'b1;
    drive(4'hD, 7'h55, 6);
    drive(4'hF, 7'h7F, 3);
    clr_on_upd = 1'b0;
    checks++; if (upd_seen !== 1)                begin errors++; $display("FAIL illegal_reupd got %0d exp 1", upd_seen); end
    checks++; if (bus.err !== 1'b1)              begin errors++; $display("FAIL illegal_set_priority got %b exp 1", bus.err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(4'hD, 7'h79, 6);
    drive(4'hF, 7'h7F, 2);
    checks++; if (bus.digit_valid !== 4'b0010)   begin errors++; $display("FAIL mid_precond got %b exp 0010", bus.digit_valid); end
    upd_seen = 0;
    drive(4'hE, 7'h24, 4);
    @(negedge clk);
    rst_n  = 1'b0;
    bus.an = 4'hF;
    #1;
    checks++; if (bus.digit_valid !== 4'b0000)   begin errors++; $display("FAIL mid_track_async got %b exp 0000", bus.digit_valid); end
    @(negedge clk); rst_n = 1'b1;
    drive(4'hF, 7'h7F, 8);
    checks++; if (upd_seen !== 0)                begin errors++; $display("FAIL mid_track_no_upd got %0d exp 0", upd_seen); end
    checks++; if (bus.digits !== 16'h0)          begin errors++; $display("FAIL mid_track_digits got %h exp 0000", bus.digits); end
    checks++; if (bus.upd_idx !== 2'd0)          begin errors++; $display("FAIL mid_track_upd_idx got %0d exp 0", bus.upd_idx); end
    // Abort a commit while upd is high: nothing may be written.
    drive(4'hB, 7'h30, 4);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.upd !== 1'b1)              begin errors++; $display("FAIL mid_commit_upd got %b exp 1", bus.upd); end
    rst_n  = 1'b0;
    bus.an = 4'hF;
    @(negedge clk); rst_n = 1'b1;
    drive(4'hF, 7'h7F, 4);
    checks++; if (bus.digit_valid !== 4'b0000)   begin errors++; $display("FAIL mid_commit_valid got %b exp 0000", bus.digit_valid); end
    checks++; if (bus.digits !== 16'h0)          begin errors++; $display("FAIL mid_commit_digits got %h exp 0000", bus.digits); end
  endtask

  task automatic test_random();
    logic [3:0] q_an [$];
    logic [6:0] q_seg [$];
    bit         exp_upd [1024];
    logic [1:0] exp_idx [1024];
    logic [3:0] m_dig [4];
    logic [3:0] m_valid;
    logic [3:0] m_blank;
    logic       m_err;
    logic [15:0] m_digits;
    logic [3:0] an;
    logic [3:0] pa;
    logic [6:0] seg;
    logic [6:0] ps;
    int         len;
    int         start;
    int         code;
    int         zi;
    int         zeros;
    int         total;

    for (int i = 0; i < 1024; i++) begin exp_upd[i] = 1'b0; exp_idx[i] = 2'd0; end
    for (int d = 0; d < 4; d++) m_dig[d] = 4'h0;
    m_valid = 4'h0; m_blank = 4'h0; m_err = 1'b0;
    pa = 4'hF; ps = 7'h7F;

    // Runs never repeat the previous sample and never end exactly at a commit edge.
    while (q_an.size() < 500) begin
      do begin
        case ($urandom_range(0, 9))
          0: an = 4'hF;
          1: an = 4'($urandom);
          default: begin an = 4'hF; an[$urandom_range(0, 3)] = 1'b0; end
        endcase
        case ($urandom_range(0, 7))
          0: seg = 7'h7F;
          1: seg = 7'($urandom);
          default: seg = PAT[$urandom_range(0, 15)];
        endcase
      end while (an == pa && seg == ps);
      len   = ($urandom_range(0, 1) == 0) ? $urandom_range(1, S - 1) : $urandom_range(S + 1, S + 4);
      start = q_an.size();
      for (int k = 0; k < len; k++) begin q_an.push_back(an); q_seg.push_back(seg); end
      zeros = 0; zi = 0;
      for (int b = 0; b < 4; b++) if (!an[b]) begin zeros++; zi = b; end
      if (zeros == 1 && len >= S) begin
        exp_upd[start + S] = 1'b1;
        exp_idx[start + S] = 2'(zi);
        code = f_lookup(seg);
        if (code >= 0 && code < 16) begin
          m_dig[zi] = 4'(code); m_valid[zi] = 1'b1; m_blank[zi] = 1'b0;
        end else if (code == 16) begin
          m_blank[zi] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
      end
      pa = an; ps = seg;
    end
    for (int k = 0; k < S + 3; k++) begin q_an.push_back(4'hF); q_seg.push_back(7'h7F); end

    apply_reset();
    total = q_an.size();
    for (int i = 0; i <= total; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus.upd !== exp_upd[i-1]) begin
          errors++; $display("FAIL rand_upd cycle %0d got %b exp %b", i - 1, bus.upd, exp_upd[i-1]);
        end
        if (exp_upd[i-1]) begin
          $display("t=%0t rand commit idx=%0d", $time, exp_idx[i-1]);
          checks++;
          if (bus.upd_idx !== exp_idx[i-1]) begin
            errors++; $display("FAIL rand_upd_idx cycle %0d got %0d exp %0d", i - 1, bus.upd_idx, exp_idx[i-1]);
          end
        end
      end
      if (i < total) begin bus.an = q_an[i]; bus.seg = q_seg[i]; end
    end
    m_digits = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
    checks++; if (bus.digits !== m_digits)       begin errors++; $display("FAIL rand_digits got %h exp %h", bus.digits, m_digits); end
    checks++; if (bus.digit_valid !== m_valid)   begin errors++; $display("FAIL rand_valid got %b exp %b", bus.digit_valid, m_valid); end
    checks++; if (bus.blank !== m_blank)         begin errors++; $display("FAIL rand_blank got %b exp %b", bus.blank, m_blank); end
    checks++; if (bus.err !== m_err)             begin errors++; $display("FAIL rand_err got %b exp %b", bus.err, m_err); end
  endtask

  initial begin
    bus.an      = 4'hF;
    bus.seg     = 7'h7F;
    bus.err_clr = 1'b0;
`ifdef SEG_CAPTURE_DP_EN
    bus.dp      = 1'b1;
`endif
    test_reset();
    test_single();
    test_blank();
    test_sequence();
    test_toggle();
    test_multi_anode();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout waiting for bench completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg_capture_decoder.md
SEG_CAPTURE_DECODER -- requirements
Module: seg_capture_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, range 2..255: consecutive identical samples required before a digit is committed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 seg  input  7  active-low segment drive; seg[0]=a … seg[6]=g.
REQ-005 an  input  4  active-low digit enables of the multiplexed display.
REQ-006 digits  output  16  decoded hex value per digit; digit k is in digits[4k+3:4k].
REQ-007 digit_valid  output  4  bit k is set once digit k has been committed with a legal hex pattern.
REQ-008 upd  output  1  one-cycle pulse on every commit.
REQ-009 upd_idx  output  2  index of the committed digit; meaningful only while upd=1.
REQ-010 blank  output  4  bit k is set when the last commit of digit k was the blank pattern 7'h7F.
REQ-011 err  output  1  sticky flag: an illegal pattern was committed.
REQ-012 err_clr  input  1  synchronous clear for err.

Function
REQ-013 seg and an shall be registered every cycle into s_seg and s_an, and all decisions shall use these sampled values.
REQ-014 Legal patterns (hex digit:seg):
- 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
- 8:00, 9:10, A:08, B:03, C:46, D:21, E:06, F:0E
- blank: 7F
- Any other value is illegal.
REQ-015 FSM states: IDLE, TRACK, COMMIT, HOLD; the reset state is IDLE.
REQ-016 IDLE→TRACK, with cnt=1, when s_an has exactly one zero bit; otherwise the FSM stays in IDLE.
REQ-017 TRACK behaviour:
- If {s_seg,s_an} equals the previous sample, cnt increments; otherwise cnt reloads to 1.
- If s_an no longer has exactly one zero, the FSM goes to IDLE.
- When cnt reaches STABLE_CYCLES, the FSM goes to COMMIT.
REQ-018 COMMIT lasts exactly one cycle and then goes to HOLD.
- upd=1 and upd_idx=active digit.
- Legal hex pattern: write digits nibble, set digit_valid bit, clear blank bit.
- Blank pattern: set blank bit; digits and digit_valid for that digit are unchanged.
- Illegal pattern: set err; the digit state is unchanged.
REQ-019 HOLD: the FSM stays while the sample is unchanged, so no repeat commits occur. On any change it goes to TRACK with cnt=1 if exactly one anode is active, else to IDLE.
REQ-020 Latency: a value first sampled at edge N and held commits with upd high in the cycle following edge N+STABLE_CYCLES.
REQ-021 Multiple or zero active anodes shall never commit.
REQ-022 err_clr clears err unless a commit in the same cycle sets it; setting has priority.
REQ-023 cnt shall saturate at STABLE_CYCLES and never wrap.

Reset
REQ-024 While rst_n=0, regardless of clk, the block shall hold:
- s_seg=7'h7F, s_an=4'hF
- FSM=IDLE, cnt=0
- digits=0, digit_valid=0, blank=0
- upd=0, upd_idx=0, err=0
REQ-025 Reset asserted mid-TRACK or mid-COMMIT shall abort with no commit; after release the block restarts from IDLE.

Configuration
REQ-026 Macro SEG_CAPTURE_DP_EN.
- Defined: the block adds input dp (1, active-low decimal point) and output dp_out (4). dp is sampled and included in the stability comparison, and COMMIT of a legal or blank pattern writes ~dp into dp_out[k]. dp_out resets to 0.
- Undefined: dp and dp_out are absent, and the stability comparison covers only seg and an.

Verification
REQ-027 STABLE_CYCLES=4. Hold an=1110, seg=24: upd=1, upd_idx=0, digits[3:0]=2, digit_valid=0001; upd pulses exactly once.
REQ-028 Cycle an=1110/seg=30, 1101/79, 1011/0E, 0111/40, holding each 6 cycles: digits=16'h0F13 and digit_valid=1111.
REQ-029 Hold an=1110 with seg toggling 24/30 every 3 cycles: no upd; then hold 30 for 4 cycles: exactly one commit with value 3.
REQ-030 Hold an=1100 with seg=00 for 20 cycles: no upd, and all outputs are unchanged.
REQ-031 Hold an=1101, seg=55 (illegal): err=1 and digit_valid[1] unchanged. Pulse err_clr: err=0. Pulse err_clr in the same cycle as another illegal commit: err stays 1.
REQ-032 Assert rst_n=0 at cnt=3 during TRACK, then release: no upd, and all outputs read their reset values.
